memory_fill_responder: RTL and testbench
========================================

MEMORY_FILL_RESPONDER -- requirements
Module: memory_fill_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request acceptance to the first returned word; legal range 2..8.
REQ-002 Parameter MEM_WORDS, default 1024: number of 16-bit words in internal storage; power of two.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req_valid  input  1  request strobe from cache fill side.
REQ-006 Port req_write  input  1  1 = single-word write, 0 = block fill (read).
REQ-007 Port req_addr  input  16  byte address; bit 0 ignored; [15:4] block, [3:1] word offset.
REQ-008 Port req_wdata  input  16  write data, sampled with an accepted write.
REQ-009 Port busy  output  1  responder cannot accept a request this cycle.
REQ-010 Port data_valid  output  1  data_out/data_addr carry a returned fill word this cycle.
REQ-011 Port data_out  output  16  returned fill word.
REQ-012 Port data_addr  output  16  byte address of data_out, bit 0 = 0.

Function
REQ-013 Storage index = addr[log2(MEM_WORDS):1]; higher address bits alias (modulo MEM_WORDS).
REQ-014 A request is accepted at a rising edge where req_valid=1 and busy=0; requests with busy=1 are ignored, not queued.
REQ-015 States: IDLE, ISSUE, DRAIN; reset enters IDLE.
REQ-016 IDLE: busy=0; accepted write -> storage updated at that edge, remain IDLE, busy stays 0.
REQ-017 IDLE: accepted read -> latch block base {req_addr[15:4],4'b0} and start offset req_addr[3:1]; go to ISSUE.
REQ-018 ISSUE: one word read per cycle for 8 cycles, offsets start, start+1, ... mod 8 (critical word first, wrap 7->0).
REQ-019 Each issued word travels a LATENCY-deep pipeline of {valid, addr, data}; data is the storage value at issue time.
REQ-020 After the 8th issue go to DRAIN; DRAIN -> IDLE when the pipeline holds no valid entry.
REQ-021 Timing: accept at edge E; word k (k=0..7) presented with data_valid=1 in the cycle following edge E+LATENCY+k; 8 consecutive valid cycles, no gaps.
REQ-022 busy=1 from the cycle after edge E through the last data_valid cycle, and 0 the cycle after; total LATENCY+8 cycles.
REQ-023 A new request may be accepted in the first cycle busy=0; back-to-back fills have exactly one idle cycle between data bursts' busy windows.
REQ-024 data_valid=0 outside the 8 burst cycles; data_out and data_addr are 16'h0000 when data_valid=0.
REQ-025 req_write and req_wdata are don't-care unless req_valid=1 and busy=0.
REQ-026 A write accepted before a fill is visible to all words of that fill.

Reset
REQ-027 rst=1 at an edge: state IDLE, issue counter 0, all pipeline valid bits 0, busy=0, data_valid=0, data_out=0, data_addr=0, regardless of state.
REQ-028 Reset mid-fill aborts the burst; no stale word is presented after reset deasserts.
REQ-029 Storage contents are not cleared by reset.
REQ-030 Requests presented while rst=1 are ignored.

Verification
REQ-031 Write 16'hA0A0+i to addresses 16'h0120+2i (i=0..7), then read 16'h0126 with LATENCY=4 -> busy 12 cycles; data_valid on edges E+4..E+11; data_addr sequence 0126,0128,012A,012C,012E,0120,0122,0124 with matching data A0A3..A0A7,A0A0..A0A2.
REQ-032 Read 16'h0120 (offset 0) -> data_addr 0120..012E in order, no wrap, data_valid exactly 8 cycles.
REQ-033 Fill request re-presented every cycle during busy -> only the first accepted; exactly 8 data_valid cycles; second fill accepted on first busy=0 cycle.
REQ-034 Assert rst for one cycle at E+6 of a fill -> data_valid=0, busy=0 from next cycle; no further valid words; next fill returns correct data.
REQ-035 Write 16'hBEEF to 16'h0800 with MEM_WORDS=1024, then read 16'h0000 -> word at data_addr 0000 returns 16'hBEEF (aliasing).
REQ-036 Write accepted in IDLE -> busy remains 0; immediate fill of the same address returns the new data.

Source files
------------

// File: rtl/memory_fill_responder.sv
// Cache-fill responder: single-word writes, 8-word critical-word-first
// block reads returned through a fixed-latency {valid, addr, data} pipe.
module memory_fill_responder #(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        data_valid,
  output logic [15:0] data_out,
  output logic [15:0] data_addr
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e state_q, state_d;
  logic [11:0] blk_q, blk_d;
  logic [2:0]  start_q, start_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [15:0] adr_q [LATENCY];
  logic [15:0] adr_d [LATENCY];
  logic [15:0] dat_q [LATENCY];
  logic [15:0] dat_d [LATENCY];
  logic [15:0] mem_q [MEM_WORDS];

  logic          accept;
  logic          wr_en;
  logic [2:0]    off;
  logic [15:0]   iss_addr;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          unused_addr0;

  assign unused_addr0 = req_addr[0];

  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    accept   = req_valid && (state_q == IDLE);
    wr_en    = accept && req_write;
    off      = 3'(start_q + cnt_q);
    iss_addr = {blk_q, off, 1'b0};
    rd_idx   = iss_addr[AW:1];
    wr_idx   = req_addr[AW:1];
    vld_d[0] = 1'b0;
    adr_d[0] = '0;
    dat_d[0] = '0;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      adr_d[i] = adr_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    unique case (state_q)
      IDLE: begin
        if (accept && !req_write) begin
          blk_d   = req_addr[15:4];
          start_d = req_addr[3:1];
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        vld_d[0] = 1'b1;
        adr_d[0] = iss_addr;
        dat_d[0] = mem_q[rd_idx];
        cnt_d    = 3'(cnt_q + 3'd1);
        if (cnt_q == 3'd7) state_d = DRAIN;
      end
      DRAIN: begin
        // leave once only the word now on the output remains in flight
        if (vld_q[LATENCY-2:0] == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      start_q <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        adr_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      for (int i = 0; i < LATENCY; i++) begin
        adr_q[i] <= adr_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_idx] <= req_wdata;
  end

  assign busy       = (state_q != IDLE);
  assign data_valid = vld_q[LATENCY-1];
  assign data_out   = data_valid ? dat_q[LATENCY-1] : 16'h0000;
  assign data_addr  = data_valid ? adr_q[LATENCY-1] : 16'h0000;

endmodule

// File: tb/tb_memory_fill_responder.sv
// Bench for memory_fill_responder: vector table, corner sequences
// and random traffic against a burst-schedule reference model.
module tb_memory_fill_responder;
  localparam int L  = 4;
  localparam int MW = 1024;

  logic        clk, rst, req_valid, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        busy, data_valid;
  logic [15:0] data_out, data_addr;

  memory_fill_responder #(.LATENCY(L), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy),
    .data_valid(data_valid), .data_out(data_out),
    .data_addr(data_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          cyc = 0;
  bit          act = 0;
  int          e_edge = 0;
  logic [11:0] m_blk;
  logic [2:0]  m_start;
  logic [15:0] snap [8];
  logic [15:0] mmem [MW];

  typedef struct {
    logic r, v, w;
    logic [15:0] a, wd;
    logic eb, edv;
    logic [15:0] ed, ea;
  } vec_t;
  vec_t tbl [21];

  task automatic chk(input string nm, input logic [15:0] a,
                     input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
    end
  endtask

  function automatic bit m_busy(input int n);
    return act && (n <= e_edge + L + 7);
  endfunction

  function automatic int idx(input logic [15:0] a);
    return int'(a[10:1]);
  endfunction

  task automatic step(input logic r, input logic v, input logic w,
                      input logic [15:0] a, input logic [15:0] wd);
    bit mb;
    logic        eb, edv;
    logic [15:0] ed, ea;
    logic [2:0]  o;
    int k;
    rst = r; req_valid = v; req_write = w;
    req_addr = a; req_wdata = wd;
    mb = m_busy(cyc);
    @(posedge clk);
    cyc++;
    if (r) act = 0;
    else if (v && !mb) begin
      if (w) mmem[idx(a)] = wd;
      else begin
        act = 1; e_edge = cyc;
        m_blk = a[15:4]; m_start = a[3:1];
        for (int j = 0; j < 8; j++)
          snap[j] = mmem[idx({a[15:4], 3'(j), 1'b0})];
      end
    end
    #1;
    eb = m_busy(cyc); edv = 0; ed = 0; ea = 0;
    if (act && cyc >= e_edge + L && cyc <= e_edge + L + 7) begin
      k = cyc - e_edge - L;
      o = m_start + 3'(k);
      edv = 1; ea = {m_blk, o, 1'b0}; ed = snap[o];
    end
    chk("busy", 16'(busy), 16'(eb));
    chk("data_valid", 16'(data_valid), 16'(edv));
    chk("data_out", data_out, ed);
    chk("data_addr", data_addr, ea);
    if (act && cyc > e_edge + L + 7) act = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    int cnt, hits;
    logic [2:0] o;
    rst = 1; req_valid = 0; req_write = 0;
    req_addr = 0; req_wdata = 0;

    // reset state
    step(1, 1, 0, 16'h0040, 16'h0);
    step(1, 0, 0, 16'h0, 16'h0);

    // load all storage so every read is defined
    for (int i = 0; i < MW; i++)
      step(0, 1, 1, 16'(i * 2), 16'($urandom));

    // table: 8 writes, read 0x0126, observe burst
    for (int i = 0; i < 21; i++)
      tbl[i] = '{0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0};
    for (int i = 0; i < 8; i++) begin
      tbl[i].v = 1; tbl[i].w = 1;
      tbl[i].a = 16'(16'h0120 + 2 * i);
      tbl[i].wd = 16'(16'hA0A0 + i);
    end
    tbl[8].v = 1; tbl[8].a = 16'h0126;
    for (int i = 8; i < 20; i++) tbl[i].eb = 1;
    for (int k = 0; k < 8; k++) begin
      o = 3'(3 + k);
      tbl[12 + k].edv = 1;
      tbl[12 + k].ea = {12'h012, o, 1'b0};
      tbl[12 + k].ed = 16'hA0A0 + 16'(o);
    end
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].wd);
      chk("tbl_busy", 16'(busy), 16'(tbl[i].eb));
      chk("tbl_dv", 16'(data_valid), 16'(tbl[i].edv));
      chk("tbl_dout", data_out, tbl[i].ed);
      chk("tbl_daddr", data_addr, tbl[i].ea);
    end

    // aligned read, no wrap
    step(0, 1, 0, 16'h0120, 16'h0);
    cnt = 0;
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 0, 16'h0, 16'h0);
      if (data_valid) begin
        chk("noWrap_addr", data_addr, 16'(16'h0120 + 2 * cnt));
        cnt++;
      end
    end
    chk("noWrap_count", 16'(cnt), 16'd8);

    // request held during busy: one burst, re-accept when free
    step(0, 1, 0, 16'h0130, 16'h0);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step(0, 1, 0, 16'h0130, 16'h0);
      if (data_valid) cnt++;
    end
    chk("held_dv_count", 16'(cnt), 16'd8);
    idle(14);

    // reset mid-fill at E+6
    step(0, 1, 0, 16'h0146, 16'h0);
    idle(5);
    step(1, 0, 0, 16'h0, 16'h0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 16'h0, 16'h0);
      if (data_valid || busy) cnt++;
    end
    chk("abort_quiet", 16'(cnt), 16'd0);
    step(0, 1, 0, 16'h0146, 16'h0);
    idle(13);

    // aliasing beyond storage size
    step(0, 1, 1, 16'h0800, 16'hBEEF);
    step(0, 1, 0, 16'h0000, 16'h0);
    hits = 0;
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 0, 16'h0, 16'h0);
      if (data_valid && data_addr == 16'h0000) begin
        hits++;
        chk("alias_data", data_out, 16'hBEEF);
      end
    end
    chk("alias_hits", 16'(hits), 16'd1);

    // write then immediate fill of same address
    step(0, 1, 1, 16'h0204, 16'h1234);
    chk("wr_not_busy", 16'(busy), 16'd0);
    step(0, 1, 0, 16'h0204, 16'h0);
    idle(13);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
           1'($urandom), 16'($urandom), 16'($urandom));
    step(1, 0, 0, 16'h0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
